uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx_sync2.sv | 27 ++
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// UART shared package: RX state encoding and frame defaults.
// Shared by the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int OS_RATE_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// UART receiver output bundle.
// Master drives received data and status; slave consumes it.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] dout;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output dout,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    input dout,
    input valid,
    input frame_err,
    input busy
  );

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both flops take RST_VAL on synchronous reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit glitch rejection,
// LSB-first data, stop-bit check, break-line lockout.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int OS_RATE   = OS_RATE_DEF
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic tick_os,
  input  logic RX_D,
  uart_rx_if.master rx
);

  localparam int OS_W = $clog2(OS_RATE);
  localparam int BC_W = $clog2(DATA_BITS);

  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OS_RATE/2 - 1);
  localparam logic [OS_W-1:0] OS_END  = OS_W'(OS_RATE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 armed_q, armed_d;

  sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk_50M),
    .rst (rst),
    .d   (RX_D),
    .q   (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    armed_d   = armed_q;
    unique case (state_q)
      IDLE: begin
        if (rx_s) armed_d = 1'b1;
        if (!rx_s && armed_q) begin
          state_d  = START;
          os_cnt_d = '0;
        end
      end
      START: begin
        if (tick_os) begin
          if (os_cnt_q == OS_MID) begin
            os_cnt_d = '0;
            if (!rx_s) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick_os) begin
          if (os_cnt_q == OS_END) begin
            os_cnt_d  = '0;
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BC_LAST) begin
              state_d   = STOP;
              bit_cnt_d = '0;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick_os) begin
          if (os_cnt_q == OS_END) begin
            os_cnt_d = '0;
            state_d  = IDLE;
            if (rx_s) begin
              dout_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              // Stop low: lock out until the line is seen idle again
              ferr_d  = 1'b1;
              armed_d = 1'b0;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      armed_q   <= armed_d;
    end
  end

  assign rx.dout      = dout_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: tick_os every 8 clocks,
// 16 ticks per bit, so one bit lasts 128 clocks.
module tb_uart_rx;

  localparam int BIT_CLKS = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_os = 1'b0;
  logic RX_D = 1'b1;

  logic [2:0] tick_cnt = '0;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] dq[$];
  int ferr_n = 0;
  int both_n = 0;
  int long_n = 0;
  logic prev_v = 1'b0;

  uart_rx_if #(.DATA_BITS(8)) rx_if ();

  uart_rx #(
    .DATA_BITS (8),
    .OS_RATE   (16)
  ) dut (
    .clk_50M (clk),
    .rst     (rst),
    .tick_os (tick_os),
    .RX_D    (RX_D),
    .rx      (rx_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_cnt = tick_cnt + 3'd1;
    tick_os  = (tick_cnt == 3'd0);
  end

  always @(negedge clk) begin
    if (rx_if.valid) dq.push_back(rx_if.dout);
    if (rx_if.frame_err) ferr_n++;
    if (rx_if.valid && rx_if.frame_err) both_n++;
    if (rx_if.valid && prev_v) long_n++;
    prev_v = rx_if.valid;
  end

  task automatic clr();
    dq.delete();
    ferr_n = 0;
    both_n = 0;
    long_n = 0;
  endtask

  task automatic drive_bit(input logic b);
    RX_D = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int bits);
    RX_D = 1'b1;
    repeat (bits * BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (rx_if.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", rx_if.dout); end
    n_chk++; if (rx_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rx_if.valid); end
    n_chk++; if (rx_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b exp 0", rx_if.frame_err); end
    n_chk++; if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", rx_if.busy); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_frame_55();
    clr();
    send_frame(8'h55, 1'b1);
    idle(2);
    n_chk++; if (dq.size() !== 1) begin n_fail++; $display("FAIL f55_count got %0d exp 1", dq.size()); end
    n_chk++; if (rx_if.dout !== 8'h55) begin n_fail++; $display("FAIL f55_dout got %h exp 55", rx_if.dout); end
    n_chk++; if (long_n !== 0) begin n_fail++; $display("FAIL f55_width long pulses %0d exp 0", long_n); end
    n_chk++; if (ferr_n !== 0) begin n_fail++; $display("FAIL f55_ferr got %0d exp 0", ferr_n); end
    n_chk++; if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL f55_busy got %b exp 0", rx_if.busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d0;
    logic [7:0] d1;
    clr();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2);
    d0 = (dq.size() > 0) ? dq[0] : 8'hxx;
    d1 = (dq.size() > 1) ? dq[1] : 8'hxx;
    n_chk++; if (dq.size() !== 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", dq.size()); end
    n_chk++; if (d0 !== 8'h00) begin n_fail++; $display("FAIL b2b_first got %h exp 00", d0); end
    n_chk++; if (d1 !== 8'hFF) begin n_fail++; $display("FAIL b2b_second got %h exp ff", d1); end
    n_chk++; if (both_n !== 0 || ferr_n !== 0) begin n_fail++; $display("FAIL b2b_ferr got %0d exp 0", ferr_n); end
  endtask

  task automatic test_glitch();
    clr();
    RX_D = 1'b0;
    repeat (20) @(negedge clk);
    n_chk++; if (rx_if.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start got %b exp 1", rx_if.busy); end
    repeat (12) @(negedge clk);
    idle(1);
    n_chk++; if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end got %b exp 0", rx_if.busy); end
    n_chk++; if (dq.size() !== 0) begin n_fail++; $display("FAIL glitch_valid got %0d exp 0", dq.size()); end
    n_chk++; if (ferr_n !== 0) begin n_fail++; $display("FAIL glitch_ferr got %0d exp 0", ferr_n); end
  endtask

  task automatic test_frame_err();
    clr();
    send_frame(8'h0F, 1'b0);
    RX_D = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    n_chk++; if (ferr_n !== 1) begin n_fail++; $display("FAIL ferr_count got %0d exp 1", ferr_n); end
    n_chk++; if (dq.size() !== 0) begin n_fail++; $display("FAIL ferr_valid got %0d exp 0", dq.size()); end
    n_chk++; if (rx_if.dout !== 8'hFF) begin n_fail++; $display("FAIL ferr_dout_hold got %h exp ff", rx_if.dout); end
    n_chk++; if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy got %b exp 0", rx_if.busy); end
    idle(2);
    send_frame(8'hA3, 1'b1);
    idle(2);
    n_chk++; if (dq.size() !== 1) begin n_fail++; $display("FAIL ferr_next_count got %0d exp 1", dq.size()); end
    n_chk++; if (rx_if.dout !== 8'hA3) begin n_fail++; $display("FAIL ferr_next_dout got %h exp a3", rx_if.dout); end
    n_chk++; if (ferr_n !== 1) begin n_fail++; $display("FAIL ferr_total got %0d exp 1", ferr_n); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'hC6;
    clr();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    RX_D = d[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (rx_if.dout !== 8'h00) begin n_fail++; $display("FAIL rmid_dout got %h exp 00", rx_if.dout); end
    n_chk++; if (rx_if.valid !== 1'b0 || rx_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL rmid_pulses got %b%b exp 00", rx_if.valid, rx_if.frame_err); end
    n_chk++; if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", rx_if.busy); end
    rst = 1'b0;
    idle(2);
    n_chk++; if (dq.size() !== 0 || ferr_n !== 0) begin n_fail++; $display("FAIL rmid_abandon got v%0d f%0d exp v0 f0", dq.size(), ferr_n); end
    send_frame(8'hC6, 1'b1);
    idle(2);
    n_chk++; if (dq.size() !== 1) begin n_fail++; $display("FAIL rmid_next_count got %0d exp 1", dq.size()); end
    n_chk++; if (rx_if.dout !== 8'hC6) begin n_fail++; $display("FAIL rmid_next_dout got %h exp c6", rx_if.dout); end
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    n_chk++; if (both_n !== 0) begin n_fail++; $display("FAIL excl_pulses got %0d exp 0", both_n); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
